// File: rtl/vga_pkg.sv
// Shared definitions for the VGA RAM arbiter.
//   state_t      : arbiter FSM states
//   BANKS_OFF    : inactive value for all low-active bank controls
//   bank_mask()  : active-high bank enables for a CPU access
//   pair_mask()  : active-high transceiver enables for the addressed bank pair
package vga_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    localparam logic [3:0] BANKS_OFF = 4'hF;

    // A1 selects the bank pair; A0 low enables the even bank, _bhe low the odd bank.
    function automatic logic [3:0] bank_mask(input logic [1:0] a, input logic bhe_n);
        logic [3:0] m;
        m = '0;
        if (!a[0])
            m[{a[1], 1'b0}] = 1'b1;
        if (!bhe_n)
            m[{a[1], 1'b1}] = 1'b1;
        return m;
    endfunction

    function automatic logic [3:0] pair_mask(input logic a1);
        return a1 ? 4'b1100 : 4'b0011;
    endfunction

endpackage

// File: rtl/vga_sync_bus.sv
// Multi-stage synchronizer for the asynchronous CPU bus bits.
//   clock     : system clock
//   reset     : synchronous, active-high; loads RESET_VAL into every stage
//   async_bus : raw CPU bus bits
//   sync_bus  : bits after STAGES flip-flops
module vga_sync_bus #(
    parameter int unsigned         STAGES    = 2,
    parameter int unsigned         WIDTH     = 6,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_bus,
    output logic [WIDTH-1:0] sync_bus
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++)
                chain[i] <= RESET_VAL;
        end else begin
            chain[0] <= async_bus;
            for (int unsigned i = 1; i < STAGES; i++)
                chain[i] <= chain[i-1];
        end
    end

    assign sync_bus = chain[STAGES-1];

endmodule

// File: rtl/vga_ram_arbiter.sv
// Shares the four byte-wide VGA SRAM banks between video fetch and CPU accesses.
//   clock, reset             : 50 MHz clock, synchronous active-high reset
//   _vga_mem,_rd,_wr,_bhe    : asynchronous low-active CPU strobes
//   addr[1:0]                : CPU A1 (bank pair) / A0 (low byte disable)
//   video_req/_banks/_soon   : fetch slot now, banks it reads, slot imminent
//   video_grant              : fetch owns the RAM this cycle (combinational)
//   _cs_ram,_we_ram          : bank chip selects / write enables (low active)
//   _cpu_ram, cpu_ram_dir    : CPU transceiver enables / direction (1 = to RAM)
//   _cpu_ram_addr            : low = CPU address drives RAM address
//   rdy                      : CPU ready, low stretches the bus cycle
//   overrun                  : sticky, fetch slot hit a CPU cycle in progress
module vga_ram_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WE_CYCLES   = 2,
    parameter int unsigned RD_CYCLES   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       _vga_mem,
    input  logic [1:0] addr,
    input  logic       _rd,
    input  logic       _wr,
    input  logic       _bhe,
    input  logic       video_req,
    input  logic [3:0] video_banks,
    input  logic       video_soon,
    output logic       video_grant,
    output logic [3:0] _cs_ram,
    output logic [3:0] _we_ram,
    output logic [3:0] _cpu_ram,
    output logic       cpu_ram_dir,
    output logic       _cpu_ram_addr,
    output logic       rdy,
    output logic       overrun
);

    localparam logic [5:0] SYNC_RESET = 6'b1111_00;
    localparam logic [2:0] WE_LIM     = 3'(WE_CYCLES);
    localparam logic [2:0] RD_LIM     = 3'(RD_CYCLES);

    logic [5:0] bus_sync;
    logic       mem_n_s, rd_n_s, wr_n_s, bhe_n_s;
    logic [1:0] addr_s;
    logic       cpu_req;

    state_t     state;
    logic [2:0] cnt;
    logic [3:0] mask_q;
    logic       is_wr_q;
    logic [3:0] cs_cpu_q, we_q, cpu_ram_q;
    logic       dir_q, addr_n_q, rdy_q, overrun_q;
    logic       cpu_idle_q;

    vga_sync_bus #(
        .STAGES    (SYNC_STAGES),
        .WIDTH     (6),
        .RESET_VAL (SYNC_RESET)
    ) u_sync (
        .clock     (clock),
        .reset     (reset),
        .async_bus ({_vga_mem, _rd, _wr, _bhe, addr}),
        .sync_bus  (bus_sync)
    );

    assign {mem_n_s, rd_n_s, wr_n_s, bhe_n_s, addr_s} = bus_sync;
    assign cpu_req = !mem_n_s && (!rd_n_s || !wr_n_s);

    // Registered CPU controls lag the state by one clock, so the first RELEASE
    // clock still shows the bank held; video may only take over once they are off.
    assign video_grant = video_req && cpu_idle_q &&
                         (state == ST_IDLE || state == ST_RELEASE);

    assign _cs_ram       = cs_cpu_q & (video_grant ? ~video_banks : BANKS_OFF);
    assign _we_ram       = we_q;
    assign _cpu_ram      = cpu_ram_q;
    assign cpu_ram_dir   = dir_q;
    assign _cpu_ram_addr = addr_n_q;
    assign rdy           = rdy_q;
    assign overrun       = overrun_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mask_q     <= '0;
            is_wr_q    <= 1'b0;
            cs_cpu_q   <= BANKS_OFF;
            we_q       <= BANKS_OFF;
            cpu_ram_q  <= BANKS_OFF;
            dir_q      <= 1'b0;
            addr_n_q   <= 1'b1;
            rdy_q      <= 1'b1;
            overrun_q  <= 1'b0;
            cpu_idle_q <= 1'b1;
        end else begin
            if (video_req && !video_grant)
                overrun_q <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        rdy_q <= 1'b0;
                        if (!video_req && !video_soon) begin
                            mask_q  <= bank_mask(addr_s, bhe_n_s);
                            is_wr_q <= !wr_n_s;
                            state   <= ST_SETUP;
                        end
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (!cpu_req) begin
                        state <= ST_RELEASE;
                    end else begin
                        cs_cpu_q   <= ~mask_q;
                        cpu_ram_q  <= ~pair_mask(addr_s[1]);
                        addr_n_q   <= 1'b0;
                        dir_q      <= is_wr_q;
                        cpu_idle_q <= 1'b0;
                        cnt        <= 3'd1;
                        state      <= ST_STROBE;
                    end
                end

                ST_STROBE: begin
                    if (!cpu_req) begin
                        we_q  <= BANKS_OFF;
                        state <= ST_RELEASE;
                    end else begin
                        if (is_wr_q)
                            we_q <= ~mask_q;
                        if (cnt >= (is_wr_q ? WE_LIM : RD_LIM))
                            state <= ST_HOLD;
                        else
                            cnt <= cnt + 3'd1;
                    end
                end

                ST_HOLD: begin
                    we_q  <= BANKS_OFF;
                    state <= ST_RELEASE;
                end

                ST_RELEASE: begin
                    cs_cpu_q   <= BANKS_OFF;
                    cpu_ram_q  <= BANKS_OFF;
                    we_q       <= BANKS_OFF;
                    addr_n_q   <= 1'b1;
                    dir_q      <= 1'b0;
                    rdy_q      <= 1'b1;
                    cpu_idle_q <= 1'b1;
                    // Only a released strobe re-arms IDLE, so one bus cycle runs once.
                    if (!cpu_req)
                        state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_ram_arbiter.sv
module tb_vga_ram_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       _vga_mem = 1'b1;
    logic [1:0] addr = 2'b00;
    logic       _rd = 1'b1;
    logic       _wr = 1'b1;
    logic       _bhe = 1'b1;
    logic       video_req = 1'b0;
    logic [3:0] video_banks = 4'b0000;
    logic       video_soon = 1'b0;
    logic       video_grant;
    logic [3:0] _cs_ram, _we_ram, _cpu_ram;
    logic       cpu_ram_dir, _cpu_ram_addr, rdy, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // {grant, rdy, overrun, dir, _addr, _cs[3:0], _we[3:0], _cpu_ram[3:0]}
    logic [16:0] obs;
    localparam logic [16:0] IDLE_V = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 4'hF};

    vga_ram_arbiter #(
        .SYNC_STAGES (2),
        .WE_CYCLES   (2),
        .RD_CYCLES   (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        ._vga_mem      (_vga_mem),
        .addr          (addr),
        ._rd           (_rd),
        ._wr           (_wr),
        ._bhe          (_bhe),
        .video_req     (video_req),
        .video_banks   (video_banks),
        .video_soon    (video_soon),
        .video_grant   (video_grant),
        ._cs_ram       (_cs_ram),
        ._we_ram       (_we_ram),
        ._cpu_ram      (_cpu_ram),
        .cpu_ram_dir   (cpu_ram_dir),
        ._cpu_ram_addr (_cpu_ram_addr),
        .rdy           (rdy),
        .overrun       (overrun)
    );

    assign obs = {video_grant, rdy, overrun, cpu_ram_dir, _cpu_ram_addr,
                  _cs_ram, _we_ram, _cpu_ram};

    always #10 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [16:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Step k counts clock edges after the CPU pins change. Two sync stages put the
    // request in front of the FSM after edge 2; detection (rdy low) on edge 3+d,
    // where d counts clocks the start is blocked. Banks held 4 clocks from the
    // next edge, WE for the middle two, rdy back high after edge 3+d+5.
    function automatic logic [16:0] expv(input int k, input int d, input logic [3:0] cs,
                                         input logic [3:0] xcv, input logic wr,
                                         input int gk, input logic [3:0] vb);
        int s;
        logic act, g, rdyv;
        logic [3:0] csv, wev, xv;
        s    = 3 + d;
        act  = (k >= s + 1) && (k <= s + 4);
        rdyv = !((k >= 3) && (k <= s + 4));
        g    = (k == gk);
        wev  = (wr && k >= s + 2 && k <= s + 3) ? cs : 4'hF;
        csv  = act ? cs : (g ? ~vb : 4'hF);
        xv   = act ? xcv : 4'hF;
        return {g, rdyv, 1'b0, act & wr, ~act, csv, wev, xv};
    endfunction

    task automatic release_pins();
        _vga_mem = 1'b1; _rd = 1'b1; _wr = 1'b1; _bhe = 1'b1; addr = 2'b00;
    endtask

    initial begin
        // Reset state
        repeat (3) begin
            step();
            chk("reset", IDLE_V);
        end
        reset = 1'b0;
        step();
        chk("post_reset", IDLE_V);

        // Word write to bank pair 0
        _vga_mem = 1'b0; _wr = 1'b0; addr = 2'b00; _bhe = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("wr_word", expv(k, 0, 4'b1100, 4'b1100, 1'b1, -1, 4'h0));
        end
        release_pins();
        repeat (4) begin
            step();
            chk("wr_word_idle", IDLE_V);
        end

        // Byte read of bank 3
        _vga_mem = 1'b0; _rd = 1'b0; addr = 2'b11; _bhe = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("rd_byte3", expv(k, 0, 4'b0111, 4'b0011, 1'b0, -1, 4'h0));
        end
        release_pins();
        repeat (4) begin
            step();
            chk("rd_byte3_idle", IDLE_V);
        end

        // Byte write to bank 0 held off by video_soon for 6 clocks
        video_soon = 1'b1;
        _vga_mem = 1'b0; _wr = 1'b0; addr = 2'b00; _bhe = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            chk("wr_soon", expv(k, 4, 4'b1110, 4'b1100, 1'b1, -1, 4'h0));
            if (k == 6)
                video_soon = 1'b0;
        end
        release_pins();
        repeat (4) begin
            step();
            chk("wr_soon_idle", IDLE_V);
        end

        // CPU request detected in the same clock as a video slot
        video_banks = 4'b0101;
        _vga_mem = 1'b0; _wr = 1'b0; addr = 2'b10; _bhe = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 2) video_req = 1'b1;
            if (k == 3) video_req = 1'b0;
            #1;
            chk("wr_vs_video", expv(k, 1, 4'b0011, 4'b0011, 1'b1, 2, 4'b0101));
        end
        release_pins();
        repeat (4) begin
            step();
            chk("wr_vs_video_idle", IDLE_V);
        end

        // video_req during STROBE, then reset in STROBE
        _vga_mem = 1'b0; _wr = 1'b0; addr = 2'b00; _bhe = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("wr_overrun", expv(k, 0, 4'b1100, 4'b1100, 1'b1, -1, 4'h0));
        end
        video_req = 1'b1;
        #1;
        n_checks++;
        assert (video_grant === 1'b0)
        else begin
            n_fail++;
            $error("FAIL grant_in_strobe: observed %b expected 0", video_grant);
        end
        step();
        video_req = 1'b0;
        n_checks++;
        assert (overrun === 1'b1)
        else begin
            n_fail++;
            $error("FAIL overrun_set: observed %b expected 1", overrun);
        end
        n_checks++;
        assert (_we_ram === 4'b1100)
        else begin
            n_fail++;
            $error("FAIL we_before_reset: observed %b expected 1100", _we_ram);
        end
        reset = 1'b1;
        release_pins();
        step();
        reset = 1'b0;
        chk("reset_in_strobe", IDLE_V);
        repeat (4) begin
            step();
            chk("after_reset_idle", IDLE_V);
        end

        // Strobe held 20 clocks past the cycle: one WE pulse, rdy stays high
        _vga_mem = 1'b0; _wr = 1'b0; addr = 2'b01; _bhe = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("wr_held", expv(k, 0, 4'b1101, 4'b1100, 1'b1, -1, 4'h0));
        end
        repeat (20) begin
            step();
            chk("wr_held_release", IDLE_V);
        end
        release_pins();
        repeat (6) begin
            step();
            chk("wr_held_idle", IDLE_V);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
